event_readout_sched: RTL

Sequencer for the event-based pixel array that turns pending pixel events into timestamped output words. It takes the ROWS×COLS array of per-pixel polarity requests and grants rows and then columns with round-robin fairness. For each granted event it emits one WIDTH-bit word over a valid/ready handshake and pulses the acknowledge of that pixel. It sits between the pixel array and the event FIFO/serializer, and uses the shared array constants.

---
 rtl/arbiter_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/event_readout_sched.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/arbiter_pkg.sv
// Shared pixel-array constants, FSM state encoding and output word layout
// for the event readout sequencer.
package arbiter_pkg;

  localparam int unsigned ARR_ROWS     = 8;
  localparam int unsigned ARR_COLS     = 8;
  localparam int unsigned ARR_POLARITY = 2;
  localparam int unsigned ARR_X_WIDTH  = 3;
  localparam int unsigned ARR_Y_WIDTH  = 3;
  localparam int unsigned ARR_SIZE     = 32;
  localparam int unsigned ARR_WIDTH    = ARR_SIZE + ARR_X_WIDTH + ARR_Y_WIDTH + 1;

  // Position of each polarity inside a pixel's request pair
  localparam int unsigned POL_ON_BIT  = 1;
  localparam int unsigned POL_OFF_BIT = 0;

  typedef enum logic [2:0] {
    IDLE,
    ROW_SEL,
    COL_SEL,
    SEND,
    ACK
  } state_e;

  typedef struct packed {
    logic [ARR_SIZE-1:0]    ts;
    logic [ARR_X_WIDTH-1:0] x;
    logic [ARR_Y_WIDTH-1:0] y;
    logic                   pol;
  } event_word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting one past last_i.
module rr_arbiter #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // First requester found walking upward (with wrap) from last_i+1
  always_comb begin
    logic          found;
    logic [IW-1:0] k;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    k       = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      k = IW'((32'(last_i) + i) % N);
      if (!found && req_i[k]) begin
        found      = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = k;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/event_readout_sched.sv
// Event readout sequencer: round-robin row/column grant of pixel requests,
// timestamped word output over valid/ready and one-cycle pixel acknowledge.
module event_readout_sched
  import arbiter_pkg::*;
#(
  parameter int unsigned ROWS     = ARR_ROWS,
  parameter int unsigned COLS     = ARR_COLS,
  parameter int unsigned POLARITY = ARR_POLARITY,
  parameter int unsigned x_width  = ARR_X_WIDTH,
  parameter int unsigned y_width  = ARR_Y_WIDTH,
  parameter int unsigned SIZE     = ARR_SIZE,
  parameter int unsigned WIDTH    = SIZE + x_width + y_width + 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [ROWS*COLS*POLARITY-1:0] events_i,
  output logic [ROWS*COLS*POLARITY-1:0] ack_o,
  output logic [WIDTH-1:0]             data_out_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  input  logic                         ts_load_i,
  input  logic [SIZE-1:0]              ts_value_i
);

  localparam int unsigned NBITS = ROWS * COLS * POLARITY;

  state_e               state_q, state_d;
  logic [SIZE-1:0]      ts_q, ts_d;
  logic [x_width-1:0]   row_ptr_q, row_ptr_d;
  logic [y_width-1:0]   col_ptr_q, col_ptr_d;
  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [NBITS-1:0]     ack_q, ack_d;

  logic [NBITS-1:0]     ev;
  logic [ROWS-1:0]      row_req;
  logic [COLS-1:0]      col_req;
  logic [POLARITY-1:0]  col_pix [COLS];
  logic [POLARITY-1:0]  sel_pix;

  logic [ROWS-1:0]      unused_row_grant;
  logic [x_width-1:0]   row_idx;
  logic                 row_any;
  logic [COLS-1:0]      col_grant;
  logic [y_width-1:0]   col_idx;
  logic                 col_any;

  // The bit being acked is still asserted by the pixel during ACK; mask it
  // so the next-state decision only sees requests that will remain.
  assign ev = events_i & ~ack_q;

  // Per-row request summary and the request pairs of the latched row
  always_comb begin
    row_req = '0;
    for (int unsigned c = 0; c < COLS; c++) col_pix[c] = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        row_req[r] = row_req[r] | (|ev[(r*COLS+c)*POLARITY +: POLARITY]);
        if (x_width'(r) == row_ptr_q) col_pix[c] = ev[(r*COLS+c)*POLARITY +: POLARITY];
      end
    end
    for (int unsigned c = 0; c < COLS; c++) col_req[c] = |col_pix[c];
  end

  // Request pair of the column the column arbiter is granting
  always_comb begin
    sel_pix = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (col_grant[c]) sel_pix = sel_pix | col_pix[c];
    end
  end

  rr_arbiter #(.N(ROWS), .IW(x_width)) u_row_arb (
    .req_i   (row_req),
    .last_i  (row_ptr_q),
    .grant_o (unused_row_grant),
    .idx_o   (row_idx),
    .any_o   (row_any)
  );

  rr_arbiter #(.N(COLS), .IW(y_width)) u_col_arb (
    .req_i   (col_req),
    .last_i  (col_ptr_q),
    .grant_o (col_grant),
    .idx_o   (col_idx),
    .any_o   (col_any)
  );

  // Timestamp counter, sequencer FSM and registered output words
  always_comb begin
    int unsigned target;
    state_d   = state_q;
    ts_d      = ts_load_i ? ts_value_i : ts_q + SIZE'(1);
    row_ptr_d = row_ptr_q;
    col_ptr_d = col_ptr_q;
    valid_d   = valid_q;
    data_d    = data_q;
    ack_d     = '0;
    target    = (32'(row_ptr_q) * COLS + 32'(col_ptr_q)) * POLARITY
              + (data_q[0] ? POL_ON_BIT : POL_OFF_BIT);
    case (state_q)
      IDLE: begin
        if (row_any) state_d = ROW_SEL;
      end
      ROW_SEL: begin
        if (row_any) begin
          row_ptr_d = row_idx;
          state_d   = COL_SEL;
        end else begin
          state_d = IDLE;
        end
      end
      COL_SEL: begin
        if (col_any) begin
          col_ptr_d = col_idx;
          data_d    = {ts_q, row_ptr_q, col_idx, sel_pix[POL_ON_BIT]};
          valid_d   = 1'b1;
          state_d   = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          ack_d   = {{(NBITS-1){1'b0}}, 1'b1} << target;
          state_d = ACK;
        end
      end
      ACK: begin
        // Leaving a drained row while other rows wait goes straight to the
        // row search; passing through IDLE would only add an idle cycle.
        if (col_any)      state_d = COL_SEL;
        else if (row_any) state_d = ROW_SEL;
        else              state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      ts_q      <= '0;
      row_ptr_q <= x_width'(ROWS - 1);
      col_ptr_q <= y_width'(COLS - 1);
      valid_q   <= 1'b0;
      data_q    <= '0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      ts_q      <= ts_d;
      row_ptr_q <= row_ptr_d;
      col_ptr_q <= col_ptr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      ack_q     <= ack_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_out_o = data_q;
  assign ack_o      = ack_q;

endmodule
